// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: default widths and FSM encoding.
package dm_arbiter_pkg;

    localparam int ADDR_W_DEF    = 9;
    localparam int DATA_W_DEF    = 16;
    localparam int MAX_BURST_DEF = 16;

    // ST_ARB: normal round-robin; ST_LOCK1: requester 1 owns the memory.
    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_LOCK1 = 1'b1
    } arb_state_t;

endpackage

// File: rtl/dm_arbiter_rr_arb2.sv
// Two-input round-robin pick returning a one-hot grant.
// i_last = 1 means requester 1 was granted most recently, so requester 0
// wins a tie. i_force_r1 restricts the grant to requester 1 only.
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_last,
    input  logic       i_force_r1,
    output logic [1:0] o_grant
);

    // Pick the winner from the valid bits and the last-granted history.
    always_comb begin
        o_grant = 2'b00;
        if (i_force_r1) begin
            o_grant[1] = i_valid[1];
        end else if (&i_valid) begin
            o_grant = i_last ? 2'b01 : 2'b10;
        end else begin
            o_grant = i_valid;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory arbiter: core (R0) and debug/loader (R1) share one single-port
// RAM. Round-robin between the two, with an optional locked burst for R1
// capped at MAX_BURST beats. Grant is combinational; read data returns one
// cycle after the accepted read.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              R0_VALID,
    input  logic              R0_WE,
    input  logic [ADDR_W-1:0] R0_ADDR,
    input  logic [DATA_W-1:0] R0_WDATA,
    output logic              R0_READY,
    output logic              R0_RVALID,
    output logic [DATA_W-1:0] R0_RDATA,
    input  logic              R1_VALID,
    input  logic              R1_WE,
    input  logic [ADDR_W-1:0] R1_ADDR,
    input  logic [DATA_W-1:0] R1_WDATA,
    output logic              R1_READY,
    output logic              R1_RVALID,
    output logic [DATA_W-1:0] R1_RDATA,
    input  logic              R1_LOCK,
    output logic              MEM_EN,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA
);

    localparam int               CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    // A one-beat cap means the lock would end on the beat that starts it.
    localparam bit               LOCK_EN = (MAX_BURST > 1);

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    logic             r_last;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_rvalid0;
    logic             r_rvalid1;
    logic [1:0]       w_grant;
    logic             w_g0;
    logic             w_g1;

    rr_arb2 u_rr_arb2 (
        .i_valid    ({R1_VALID, R0_VALID}),
        .i_last     (r_last),
        .i_force_r1 (r_state == ST_LOCK1),
        .o_grant    (w_grant)
    );

    // Grants are masked while reset is held so nothing reaches the RAM.
    assign w_g0 = w_grant[0] & RST;
    assign w_g1 = w_grant[1] & RST;

    assign R0_READY  = w_g0;
    assign R1_READY  = w_g1;
    assign MEM_EN    = w_g0 | w_g1;
    assign MEM_WE    = (w_g1 & R1_WE) | (w_g0 & R0_WE);
    assign MEM_ADDR  = w_g1 ? R1_ADDR  : (w_g0 ? R0_ADDR  : '0);
    assign MEM_WDATA = w_g1 ? R1_WDATA : (w_g0 ? R0_WDATA : '0);

    // Read data is forwarded straight from the RAM and forced to 0 otherwise.
    assign R0_RVALID = r_rvalid0;
    assign R1_RVALID = r_rvalid1;
    assign R0_RDATA  = r_rvalid0 ? MEM_RDATA : '0;
    assign R1_RDATA  = r_rvalid1 ? MEM_RDATA : '0;

    // Next-state and beat counter: enter the lock on a locked R1 grant, leave
    // when R1 lets go of VALID or LOCK, or when the burst cap is reached.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_ARB: begin
                if (LOCK_EN && w_g1 && R1_LOCK) begin
                    w_state_next = ST_LOCK1;
                    w_cnt_next   = CNT_W'(1);
                end
            end
            ST_LOCK1: begin
                if (!R1_VALID || !R1_LOCK) begin
                    w_state_next = ST_ARB;
                    w_cnt_next   = '0;
                end else if ((r_cnt + CNT_W'(1)) == CNT_MAX) begin
                    w_state_next = ST_ARB;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = ST_ARB;
                w_cnt_next   = '0;
            end
        endcase
    end

    // State, history and read-return registers; reset drops any read in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= ST_ARB;
            r_last    <= 1'b1;
            r_cnt     <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            if (w_g0 | w_g1) begin
                r_last <= w_g1;
            end
            r_rvalid0 <= w_g0 & ~R0_WE;
            r_rvalid1 <= w_g1 & ~R1_WE;
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios plus randomized
// traffic, all compared cycle by cycle against a behavioural model.
module tb_dm_arbiter;

    localparam int AW   = 9;
    localparam int DW   = 16;
    localparam int MAXB = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          r0_valid, r0_we, r0_ready, r0_rvalid;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata, r0_rdata;
    logic          r1_valid, r1_we, r1_ready, r1_rvalid, r1_lock;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata, r1_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAXB)) dut (
        .CLK(clk), .RST(rst_n),
        .R0_VALID(r0_valid), .R0_WE(r0_we), .R0_ADDR(r0_addr), .R0_WDATA(r0_wdata),
        .R0_READY(r0_ready), .R0_RVALID(r0_rvalid), .R0_RDATA(r0_rdata),
        .R1_VALID(r1_valid), .R1_WE(r1_we), .R1_ADDR(r1_addr), .R1_WDATA(r1_wdata),
        .R1_READY(r1_ready), .R1_RVALID(r1_rvalid), .R1_RDATA(r1_rdata),
        .R1_LOCK(r1_lock),
        .MEM_EN(mem_en), .MEM_WE(mem_we), .MEM_ADDR(mem_addr),
        .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_rdata)
    );

    // Single-port RAM with one-cycle registered read.
    logic [DW-1:0] ram [512];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Behavioural model: expected memory contents, who went last, burst owner.
    logic [DW-1:0] shadow [512];
    bit            m_burst, m_last, m_rv0, m_rv1, m_g0, m_g1;
    int            m_beats;
    logic [DW-1:0] m_rd0, m_rd1;

    logic          obs_g0, obs_g1, obs_rv0, obs_rv1;
    logic [DW-1:0] obs_rd0, obs_rd1;
    logic [AW-1:0] obs_addr;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_burst = 0;
        m_beats = 0;
        m_last  = 1;
        m_rv0   = 0;
        m_rv1   = 0;
    endtask

    // One clock cycle: inputs already driven at the falling edge; check the
    // DUT just after, advance the model, then wait for the next falling edge.
    task automatic step();
        #2;
        if (!rst_n) model_reset();
        if (!rst_n) begin
            m_g0 = 0; m_g1 = 0;
        end else if (m_burst) begin
            m_g0 = 0; m_g1 = r1_valid;
        end else if (r0_valid && r1_valid) begin
            m_g0 = m_last; m_g1 = !m_last;
        end else begin
            m_g0 = r0_valid; m_g1 = r1_valid;
        end

        check("r0_ready", r0_ready, m_g0);
        check("r1_ready", r1_ready, m_g1);
        check("mem_en", mem_en, m_g0 | m_g1);
        if (m_g0 || m_g1) begin
            check("mem_we", mem_we, m_g1 ? r1_we : r0_we);
            check("mem_addr", mem_addr, m_g1 ? r1_addr : r0_addr);
            if (m_g1 ? r1_we : r0_we)
                check("mem_wdata", mem_wdata, m_g1 ? r1_wdata : r0_wdata);
        end else begin
            check("mem_we_idle", mem_we, 0);
        end
        check("r0_rvalid", r0_rvalid, m_rv0);
        check("r0_rdata", r0_rdata, m_rv0 ? m_rd0 : '0);
        check("r1_rvalid", r1_rvalid, m_rv1);
        check("r1_rdata", r1_rdata, m_rv1 ? m_rd1 : '0);

        obs_g0 = r0_ready;  obs_g1 = r1_ready;
        obs_rv0 = r0_rvalid; obs_rv1 = r1_rvalid;
        obs_rd0 = r0_rdata;  obs_rd1 = r1_rdata;
        obs_addr = mem_addr;
        if (m_g0 || m_g1)
            $display("t=%0t grant r%0d %s addr=%0d lock=%0b", $time, m_g1 ? 1 : 0,
                     (m_g1 ? r1_we : r0_we) ? "wr" : "rd", m_g1 ? r1_addr : r0_addr, r1_lock);

        if (rst_n) begin
            m_rv0 = m_g0 && !r0_we;
            m_rv1 = m_g1 && !r1_we;
            m_rd0 = shadow[r0_addr];
            m_rd1 = shadow[r1_addr];
            if (m_g0 && r0_we) shadow[r0_addr] = r0_wdata;
            if (m_g1 && r1_we) shadow[r1_addr] = r1_wdata;
            if (m_g0 || m_g1) m_last = m_g1;
            if (m_burst) begin
                if (!r1_valid || !r1_lock) m_burst = 0;
                else begin
                    m_beats++;
                    if (m_beats == MAXB) m_burst = 0;
                end
            end else if (m_g1 && r1_lock) begin
                m_burst = 1;
                m_beats = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        r0_valid = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
        r1_valid = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0; r1_lock = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        step();
        rst_n = 1;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            ram[i]    = DW'($urandom);
            shadow[i] = ram[i];
        end
        model_reset();
        rst_n = 0;
        idle();
        // Both requesting during reset: nothing may be granted.
        r0_valid = 1; r1_valid = 1;
        @(negedge clk);
        step();
        step();
        check("rst_no_en", obs_g0 | obs_g1, 0);
        rst_n = 1;

        // Alternating reads at addresses 5 and 9.
        r0_addr = 9'd5; r1_addr = 9'd9;
        for (int i = 0; i < 4; i++) begin
            step();
            check("alt_r1_grant", obs_g1, (i % 2));
            check("alt_r0_grant", obs_g0, ((i + 1) % 2));
        end
        idle();
        step();
        check("alt_last_rvalid", obs_rv1, 1);

        // Write then read-back of the same word.
        r1_valid = 1; r1_we = 1; r1_addr = 9'd3; r1_wdata = 16'h00AB;
        step();
        idle();
        r0_valid = 1; r0_addr = 9'd3;
        step();
        idle();
        step();
        check("wr_rd_data", obs_rd0, 16'h00AB);

        // Locked burst capped at MAXB while R0 waits.
        do_reset();
        idle();
        r1_valid = 1; r1_lock = 1; r1_we = 1;
        for (int i = 0; i <= MAXB; i++) begin
            if (i == 1) begin r0_valid = 1; r0_addr = 9'd7; end
            r1_addr = AW'(i); r1_wdata = DW'(i * 3);
            step();
            check("cap_r1_grant", obs_g1, (i < MAXB) ? 1 : 0);
            check("cap_r0_grant", obs_g0, (i == MAXB) ? 1 : 0);
        end
        idle();
        step();

        // Lock released after beat 3; the fourth beat is unlocked.
        do_reset();
        idle();
        for (int i = 0; i < 5; i++) begin
            r1_valid = (i < 4); r1_lock = (i < 3); r1_we = 0; r1_addr = AW'(20 + i);
            r0_valid = (i >= 1); r0_addr = 9'd30;
            step();
            check("unlock_r1_grant", obs_g1, (i < 4) ? 1 : 0);
            check("unlock_r0_grant", obs_g0, (i == 4) ? 1 : 0);
        end
        idle();
        step();

        // Reset right after an accepted read.
        do_reset();
        idle();
        r0_valid = 1; r0_addr = 9'd11;
        step();
        r0_valid = 0;
        rst_n = 0;
        step();
        check("rst_read_abort", obs_rv0, 0);
        rst_n = 1;
        r0_valid = 1; r1_valid = 1; r1_addr = 9'd12;
        step();
        check("post_rst_r0_first", obs_g0, 1);
        idle();
        step();

        // Sequential sweep of all addresses with wrap.
        do_reset();
        idle();
        r0_valid = 1;
        for (int i = 0; i <= 512; i++) begin
            r0_addr = AW'(i % 512);
            step();
            check("sweep_grant", obs_g0, 1);
            check("sweep_addr", obs_addr, (i % 512));
            if (i > 0) check("sweep_rvalid", obs_rv0, 1);
        end
        idle();
        step();

        // Randomized traffic; requests held until accepted, occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if (!r0_valid || m_g0) begin
                r0_valid = ($urandom_range(0, 3) != 0);
                r0_we    = 1'($urandom_range(0, 1));
                r0_addr  = AW'($urandom_range(0, 511));
                r0_wdata = DW'($urandom);
            end
            if (!r1_valid || m_g1) begin
                r1_valid = ($urandom_range(0, 4) != 0);
                r1_we    = 1'($urandom_range(0, 1));
                r1_addr  = AW'($urandom_range(0, 511));
                r1_wdata = DW'($urandom);
                r1_lock  = r1_lock ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 3) == 0);
            end
            rst_n = ($urandom_range(0, 299) != 0);
            step();
        end
        rst_n = 1;
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter ADDR_W, default 9, data-memory word-address width (512 words).
REQ-002 Parameter DATA_W, default 16, data-memory word width.
REQ-003 Parameter MAX_BURST, default 16, maximum locked beats for requester 1.
REQ-004 Ports, in order: name, direction, width, meaning.
- CLK  in  1  single clock; all state on rising edge.
- RST  in  1  reset, asynchronous, active-low.
- R0_VALID  in  1  core request.
- R0_WE  in  1  core write (1) / read (0).
- R0_ADDR  in  ADDR_W  core address.
- R0_WDATA  in  DATA_W  core write data.
- R0_READY  out  1  core request accepted this cycle.
- R0_RVALID  out  1  core read data valid.
- R0_RDATA  out  DATA_W  core read data.
- R1_VALID, R1_WE, R1_ADDR, R1_WDATA, R1_READY, R1_RVALID, R1_RDATA: same as R0_*, for the debug/loader port.
- R1_LOCK  in  1  requester 1 requests a locked burst.
- MEM_EN  out  1  RAM access strobe.
- MEM_WE  out  1  RAM write enable.
- MEM_ADDR  out  ADDR_W  RAM address.
- MEM_WDATA  out  DATA_W  RAM write data.
- MEM_RDATA  in  DATA_W  RAM read data, valid one cycle after a MEM_EN read.

Function
REQ-005 A transfer occurs on a cycle where Rn_VALID and Rn_READY are both 1. At most one READY is 1 per cycle.
REQ-006 READY is combinational from VALID and the registered state. The winner's WE/ADDR/WDATA drive MEM_* in the same cycle, with MEM_EN=1. With no winner: MEM_EN=0, MEM_WE=0.
REQ-007 Round-robin: a 1-bit LAST register holds the last granted requester. On a tie, the other requester wins. A single valid requester wins unconditionally.
REQ-008 Read latency is 1. The cycle after an accepted read, Rn_RVALID=1 and Rn_RDATA=MEM_RDATA. Writes produce no RVALID. Rn_RDATA is 0 whenever Rn_RVALID=0.
REQ-009 FSM states ARB and LOCK1.
- ARB -> LOCK1 when requester 1 is granted with R1_LOCK=1. The beat counter loads 1 on that transition.
- In LOCK1, only requester 1 may be granted; R0_READY=0. Each accepted beat increments the counter.
- LOCK1 -> ARB when R1_LOCK=0 is sampled, or R1_VALID=0 is sampled, or the counter reaches MAX_BURST.
REQ-010 After the MAX_BURST exit from LOCK1, LAST=1. If R0_VALID=1 in the next cycle, requester 0 wins that cycle regardless of R1_LOCK (no starvation).
REQ-011 Back-to-back transfers are permitted every cycle. Throughput is 1 access per cycle.
REQ-012 A requester holds VALID/WE/ADDR/WDATA stable until READY. The arbiter does not check this.
REQ-013 A read accepted in the same cycle as a FSM transition still returns RVALID in the next cycle.

Reset
REQ-014 While RST=0: FSM=ARB, LAST=1, counter=0, R0_RVALID=R1_RVALID=0, RDATA=0, R0_READY=R1_READY=0, MEM_EN=MEM_WE=0.
REQ-015 RST asserted mid-burst or mid-read aborts it. No RVALID is issued after reset release for a pre-reset read.
REQ-016 On the first cycle after release with both valid, requester 0 wins.

Structure
REQ-017 A shared package holds ADDR_W/DATA_W defaults (9/16) and the FSM state encoding (ARB=0, LOCK1=1).
REQ-018 One sub-module, rr_arb2: a 2-input round-robin pick taking the valid bits, LAST and a force-r1 input, and returning a one-hot grant.

Verification
REQ-019 Both VALID for 4 cycles (reads, addresses 5 and 9) -> grants alternate 0,1,0,1. RVALID is seen one cycle after each grant with the RAM contents.
REQ-020 R1 writes 0x00AB at address 3, then R0 reads address 3 the next cycle -> R0_RDATA=0x00AB two cycles after the write grant.
REQ-021 R1_LOCK=1 with 20 beats while R0_VALID=1 continuously -> R1 receives 16 consecutive grants, then R0 is granted on cycle 17.
REQ-022 R1_LOCK drops after beat 3 -> FSM returns to ARB. R0 is granted the next cycle.
REQ-023 RST=0 asserted the cycle after an accepted read -> no RVALID. After release, both valid -> R0 is granted first.
REQ-024 Only R0 valid, reading addresses 0..511 sequentially -> 512 grants in 512 cycles. RVALID is continuous and MEM_ADDR wraps cleanly from 511 to 0.
